// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer behind the UART receiver: decodes multi-byte frames into RF writes/reads
// and ALU operations, and returns read data / ALU results as bytes to the TX FIFO.
module uart_rx_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  input  logic                      rx_valid,
  input  logic                      rx_par_err,
  input  logic                      rx_frm_err,
  output logic                      RF_WrEn,
  output logic                      RF_RdEn,
  output logic [ADDR_WIDTH-1:0]     RF_Address,
  output logic [DATA_WIDTH-1:0]     RF_WrData,
  input  logic [DATA_WIDTH-1:0]     RF_RdData,
  input  logic                      RF_RdData_Vld,
  output logic                      ALU_EN,
  output logic [3:0]                ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  output logic                      CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      tx_push,
  input  logic                      tx_full,
  output logic                      busy,
  output logic                      cmd_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_OP_A, S_OP_B,
    S_FUN, S_ALU_START, S_ALU_WAIT, S_TX_LO, S_TX_HI
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);
  localparam logic [7:0]            TO_LAST = 8'(TIMEOUT - 1);

  state_t                  state_reg, state_next;
  logic [7:0]              cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg, wr_addr_next;
  logic [ADDR_WIDTH-1:0]   rf_addr_reg, rf_addr_next;
  logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;
  logic                    wr_en_reg, wr_en_next;
  logic                    rd_en_reg, rd_en_next;
  logic                    alu_en_reg, alu_en_next;
  logic [3:0]              alu_fun_reg, alu_fun_next;
  logic                    gate_reg, gate_next;
  logic [2*DATA_WIDTH-1:0] res_reg, res_next;
  logic                    two_reg, two_next;
  logic                    err_reg, err_next;
  logic                    byte_ok, byte_bad, rx_state;

  assign byte_ok  = rx_valid && !rx_par_err && !rx_frm_err;
  assign byte_bad = rx_valid && (rx_par_err || rx_frm_err);
  assign rx_state = (state_reg == S_IDLE)   || (state_reg == S_WR_ADDR) ||
                    (state_reg == S_WR_DATA) || (state_reg == S_RD_ADDR) ||
                    (state_reg == S_OP_A)    || (state_reg == S_OP_B)    ||
                    (state_reg == S_FUN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      wr_addr_reg <= '0;
      rf_addr_reg <= '0;
      wr_data_reg <= '0;
      wr_en_reg   <= 1'b0;
      rd_en_reg   <= 1'b0;
      alu_en_reg  <= 1'b0;
      alu_fun_reg <= '0;
      gate_reg    <= 1'b0;
      res_reg     <= '0;
      two_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      wr_addr_reg <= wr_addr_next;
      rf_addr_reg <= rf_addr_next;
      wr_data_reg <= wr_data_next;
      wr_en_reg   <= wr_en_next;
      rd_en_reg   <= rd_en_next;
      alu_en_reg  <= alu_en_next;
      alu_fun_reg <= alu_fun_next;
      gate_reg    <= gate_next;
      res_reg     <= res_next;
      two_reg     <= two_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = '0;
    wr_addr_next = wr_addr_reg;
    rf_addr_next = rf_addr_reg;
    wr_data_next = wr_data_reg;
    wr_en_next   = 1'b0;
    rd_en_next   = 1'b0;
    alu_en_next  = 1'b0;
    alu_fun_next = alu_fun_reg;
    gate_next    = gate_reg;
    res_next     = res_reg;
    two_next     = two_reg;
    err_next     = 1'b0;

    // Receive states act on clean bytes here; corrupted bytes are handled after the case.
    case (state_reg)
      S_IDLE: if (byte_ok) begin
        case (rx_data)
          CMD_WR:  state_next = S_WR_ADDR;
          CMD_RD:  state_next = S_RD_ADDR;
          CMD_OP:  state_next = S_OP_A;
          CMD_FUN: state_next = S_FUN;
          default: err_next   = 1'b1;
        endcase
      end
      S_WR_ADDR: if (byte_ok) begin
        wr_addr_next = rx_data[ADDR_WIDTH-1:0];
        state_next   = S_WR_DATA;
      end
      S_WR_DATA: if (byte_ok) begin
        wr_en_next   = 1'b1;
        rf_addr_next = wr_addr_reg;
        wr_data_next = rx_data;
        state_next   = S_IDLE;
      end
      S_RD_ADDR: if (byte_ok) begin
        rd_en_next   = 1'b1;
        rf_addr_next = rx_data[ADDR_WIDTH-1:0];
        state_next   = S_RD_WAIT;
      end
      S_OP_A, S_OP_B: if (byte_ok) begin
        wr_en_next   = 1'b1;
        rf_addr_next = (state_reg == S_OP_A) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
        wr_data_next = rx_data;
        state_next   = (state_reg == S_OP_A) ? S_OP_B : S_FUN;
      end
      S_FUN: if (byte_ok) begin
        alu_fun_next = rx_data[3:0];
        gate_next    = 1'b1;
        state_next   = S_ALU_START;
      end
      // The gated ALU clock runs one cycle before the start strobe.
      S_ALU_START: begin
        err_next    = rx_valid;
        alu_en_next = 1'b1;
        state_next  = S_ALU_WAIT;
      end
      S_RD_WAIT: begin
        err_next = rx_valid;
        if (RF_RdData_Vld) begin
          res_next   = {{DATA_WIDTH{1'b0}}, RF_RdData};
          two_next   = 1'b0;
          state_next = S_TX_LO;
        end else if (cnt_reg == TO_LAST) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      S_ALU_WAIT: begin
        err_next = rx_valid;
        if (ALU_OUT_VLD) begin
          res_next   = ALU_OUT;
          two_next   = 1'b1;
          gate_next  = 1'b0;
          state_next = S_TX_LO;
        end else if (cnt_reg == TO_LAST) begin
          err_next   = 1'b1;
          gate_next  = 1'b0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      S_TX_LO: begin
        err_next = rx_valid;
        if (!tx_full) state_next = two_reg ? S_TX_HI : S_IDLE;
      end
      S_TX_HI: begin
        err_next = rx_valid;
        if (!tx_full) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (rx_state && byte_bad) begin
      err_next   = 1'b1;
      state_next = S_IDLE;
    end
  end

  assign RF_WrEn     = wr_en_reg;
  assign RF_RdEn     = rd_en_reg;
  assign RF_Address  = rf_addr_reg;
  assign RF_WrData   = wr_data_reg;
  assign ALU_EN      = alu_en_reg;
  assign ALU_FUN     = alu_fun_reg;
  assign CLK_GATE_EN = gate_reg;
  assign cmd_err     = err_reg;
  assign busy        = (state_reg != S_IDLE);
  assign tx_push     = ((state_reg == S_TX_LO) || (state_reg == S_TX_HI)) && !tx_full;
  assign tx_data     = (state_reg == S_TX_HI) ? res_reg[2*DATA_WIDTH-1:DATA_WIDTH]
                                              : res_reg[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: directed frames plus random frames checked against an
// expectation model built from the command rules (expected RF/ALU/TX events and error count).
module tb_uart_rx_cmd_ctrl;
  localparam int TMO = 20;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, rx_par_err = 1'b0, rx_frm_err = 1'b0;
  logic        RF_WrEn, RF_RdEn;
  logic [3:0]  RF_Address;
  logic [7:0]  RF_WrData;
  logic [7:0]  RF_RdData = '0;
  logic        RF_RdData_Vld = 1'b0;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        CLK_GATE_EN;
  logic [7:0]  tx_data;
  logic        tx_push;
  logic        tx_full = 1'b0;
  logic        busy, cmd_err;

  uart_rx_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_par_err(rx_par_err), .rx_frm_err(rx_frm_err),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .RF_RdData(RF_RdData), .RF_RdData_Vld(RF_RdData_Vld),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .CLK_GATE_EN(CLK_GATE_EN), .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;

  // Expected events for the current transaction and what was observed.
  logic [11:0] exp_wr[$], got_wr[$];
  logic [3:0]  exp_rd[$], got_rd[$], exp_alu[$], got_alu[$];
  logic [7:0]  exp_tx[$], got_tx[$];
  int          exp_err, err_seen;
  logic [9:0]  cmd_q[$];
  bit          stray;

  // Responder settings and state.
  int          rd_delay, alu_delay, full_hold;
  logic [7:0]  rd_value;
  logic [15:0] alu_value;
  bit          rd_pend, alu_pend;
  int          rd_cnt, alu_cnt, full_cnt;
  int          cyc, rden_cyc, alu_en_cyc, err_cyc, vld_cyc, first_push_cyc;
  int          alu_viol, full_viol;
  logic [3:0]  fun_at_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RF / ALU / TX-FIFO responders, then output monitor sampled 1 ns after the falling edge.
  always @(negedge CLK) begin
    cyc++;
    RF_RdData_Vld = 1'b0;
    ALU_OUT_VLD   = 1'b0;
    if (RST) begin
      rd_pend = 0; alu_pend = 0; full_cnt = 0; tx_full = 1'b0;
    end else begin
      if (full_cnt > 0) begin
        full_cnt--;
        if (full_cnt == 0) tx_full = 1'b0;
      end
      if (rd_pend) begin
        if (rd_cnt == 1) begin
          RF_RdData_Vld = 1'b1; RF_RdData = rd_value; rd_pend = 0; vld_cyc = cyc;
          if (full_hold > 0) begin tx_full = 1'b1; full_cnt = full_hold; end
        end else rd_cnt--;
      end
      if (alu_pend) begin
        if (alu_cnt == 1) begin
          ALU_OUT_VLD = 1'b1; ALU_OUT = alu_value; alu_pend = 0; vld_cyc = cyc;
          if (full_hold > 0) begin tx_full = 1'b1; full_cnt = full_hold; end
        end else alu_cnt--;
      end
      if (RF_RdEn && rd_delay != 0) begin rd_pend = 1; rd_cnt = rd_delay; end
      if (ALU_EN && alu_delay != 0) begin alu_pend = 1; alu_cnt = alu_delay; end
    end
    #1;
    if (!RST) begin
      if (RF_WrEn) got_wr.push_back({RF_Address, RF_WrData});
      if (RF_RdEn) begin got_rd.push_back(RF_Address); rden_cyc = cyc; end
      if (ALU_EN) begin got_alu.push_back(ALU_FUN); alu_en_cyc = cyc; fun_at_en = ALU_FUN; end
      if ((ALU_EN || alu_pend) && !CLK_GATE_EN) alu_viol++;
      if ((alu_pend || ALU_OUT_VLD) && ALU_FUN != fun_at_en) alu_viol++;
      if (tx_push) begin
        got_tx.push_back(tx_data);
        if (first_push_cyc < 0) first_push_cyc = cyc;
        if (tx_full) full_viol++;
      end
      if (cmd_err) begin err_seen++; err_cyc = cyc; end
    end
  end

  task automatic send(input logic [9:0] e);
    rx_data = e[7:0]; rx_par_err = e[9]; rx_frm_err = e[8]; rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0; rx_par_err = 1'b0; rx_frm_err = 1'b0;
  endtask

  task automatic clear_exp();
    exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_tx.delete(); cmd_q.delete();
    exp_err = 0; stray = 0; rd_delay = 3; alu_delay = 3; full_hold = 0;
    rd_value = '0; alu_value = '0;
  endtask

  task automatic run_txn(input string name);
    int n;
    got_wr.delete(); got_rd.delete(); got_alu.delete(); got_tx.delete();
    err_seen = 0; alu_viol = 0; full_viol = 0; first_push_cyc = -1;
    @(negedge CLK);
    foreach (cmd_q[i]) begin
      send(cmd_q[i]);
      if (i != cmd_q.size() - 1) repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    if (stray) send(10'($urandom));
    n = 0;
    #2;
    while ((busy || rd_pend || alu_pend || full_cnt != 0) && n < 400) begin
      @(negedge CLK); #2; n++;
    end
    check({name, ".settle"}, 32'(n < 400), 32'd1);
    repeat (3) @(negedge CLK);
    #2;
    check({name, ".n_wr"}, got_wr.size(), exp_wr.size());
    foreach (exp_wr[i]) check({name, ".wr"}, (i < got_wr.size()) ? 32'(got_wr[i]) : 32'hxxxxxxxx, 32'(exp_wr[i]));
    check({name, ".n_rd"}, got_rd.size(), exp_rd.size());
    foreach (exp_rd[i]) check({name, ".rd_addr"}, (i < got_rd.size()) ? 32'(got_rd[i]) : 32'hxxxxxxxx, 32'(exp_rd[i]));
    check({name, ".n_alu"}, got_alu.size(), exp_alu.size());
    foreach (exp_alu[i]) check({name, ".alu_fun"}, (i < got_alu.size()) ? 32'(got_alu[i]) : 32'hxxxxxxxx, 32'(exp_alu[i]));
    check({name, ".n_tx"}, got_tx.size(), exp_tx.size());
    foreach (exp_tx[i]) check({name, ".tx_data"}, (i < got_tx.size()) ? 32'(got_tx[i]) : 32'hxxxxxxxx, 32'(exp_tx[i]));
    check({name, ".cmd_err"}, err_seen, exp_err);
    check({name, ".alu_gate_fun"}, alu_viol, 0);
    check({name, ".push_full"}, full_viol, 0);
    check({name, ".idle"}, {busy, CLK_GATE_EN}, 2'b00);
    $display("TXN %-12s bytes=%0d wr=%0d rd=%0d alu=%0d tx=%0d err=%0d",
             name, cmd_q.size(), got_wr.size(), got_rd.size(), got_alu.size(), got_tx.size(), err_seen);
  endtask

  function automatic bit is_cmd(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hBB) || (b == 8'hCC) || (b == 8'hDD);
  endfunction

  task automatic build_random(output string name);
    logic [7:0] a, d, x, y, f, b;
    int k, p;
    a = 8'($urandom); d = 8'($urandom); x = 8'($urandom); y = 8'($urandom); f = 8'($urandom);
    k = $urandom_range(0, 6);
    case (k)
      0: begin
        name = "r_write";
        cmd_q = '{{2'b00, 8'hAA}, {2'b00, a}, {2'b00, d}};
        exp_wr.push_back({a[3:0], d});
      end
      1: begin
        name = "r_read";
        cmd_q = '{{2'b00, 8'hBB}, {2'b00, a}};
        rd_delay = $urandom_range(1, 6); rd_value = 8'($urandom);
        full_hold = $urandom_range(0, 4); stray = bit'($urandom_range(0, 1));
        exp_rd.push_back(a[3:0]); exp_tx.push_back(rd_value); exp_err = int'(stray);
      end
      2, 3: begin
        name = (k == 2) ? "r_op" : "r_fun";
        if (k == 2) begin
          cmd_q = '{{2'b00, 8'hCC}, {2'b00, x}, {2'b00, y}, {2'b00, f}};
          exp_wr.push_back({4'd0, x}); exp_wr.push_back({4'd1, y});
        end else cmd_q = '{{2'b00, 8'hDD}, {2'b00, f}};
        alu_delay = $urandom_range(1, 6); alu_value = 16'($urandom);
        full_hold = $urandom_range(0, 4); stray = bit'($urandom_range(0, 1));
        exp_alu.push_back(f[3:0]);
        exp_tx.push_back(alu_value[7:0]); exp_tx.push_back(alu_value[15:8]);
        exp_err = int'(stray);
      end
      4: begin
        name = "r_abort";
        p = $urandom_range(0, 6);
        case (p)
          0: cmd_q = '{{2'b00, 8'hAA}};
          1: cmd_q = '{{2'b00, 8'hAA}, {2'b00, a}};
          2: cmd_q = '{{2'b00, 8'hBB}};
          3: cmd_q = '{{2'b00, 8'hCC}};
          4: cmd_q = '{{2'b00, 8'hCC}, {2'b00, x}};
          5: cmd_q = '{{2'b00, 8'hCC}, {2'b00, x}, {2'b00, y}};
          default: cmd_q = '{{2'b00, 8'hDD}};
        endcase
        if (p >= 4 && p <= 5) exp_wr.push_back({4'd0, x});
        if (p == 5) exp_wr.push_back({4'd1, y});
        cmd_q.push_back({2'($urandom_range(1, 3)), d});
        exp_err = 1;
      end
      5: begin
        name = "r_junk";
        b = 8'($urandom);
        while (is_cmd(b)) b = 8'($urandom);
        if ($urandom_range(0, 1) == 1) cmd_q = '{{2'($urandom_range(1, 3)), d}};
        else cmd_q = '{{2'b00, b}};
        exp_err = 1;
      end
      default: begin
        name = "r_timeout";
        if ($urandom_range(0, 1) == 1) begin
          cmd_q = '{{2'b00, 8'hBB}, {2'b00, a}};
          rd_delay = 0; exp_rd.push_back(a[3:0]);
        end else begin
          cmd_q = '{{2'b00, 8'hDD}, {2'b00, f}};
          alu_delay = 0; exp_alu.push_back(f[3:0]);
        end
        exp_err = 1;
      end
    endcase
  endtask

  initial begin
    string name;
    cyc = 0; rd_pend = 0; alu_pend = 0; full_cnt = 0; fun_at_en = '0;
    clear_exp();
    repeat (3) @(negedge CLK);
    #1;
    check("reset_outputs", {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                            CLK_GATE_EN, tx_data, tx_push, busy, cmd_err}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    clear_exp();
    cmd_q = '{10'h0AA, 10'h005, 10'h03C};
    exp_wr.push_back({4'h5, 8'h3C});
    run_txn("write");

    clear_exp();
    cmd_q = '{10'h0BB, 10'h002};
    rd_delay = 3; rd_value = 8'h7E;
    exp_rd.push_back(4'h2); exp_tx.push_back(8'h7E);
    run_txn("read");

    clear_exp();
    cmd_q = '{10'h0CC, 10'h010, 10'h020, 10'h000};
    alu_delay = 4; alu_value = 16'h0030;
    exp_wr.push_back({4'h0, 8'h10}); exp_wr.push_back({4'h1, 8'h20});
    exp_alu.push_back(4'h0); exp_tx.push_back(8'h30); exp_tx.push_back(8'h00);
    run_txn("op");

    clear_exp();
    cmd_q = '{10'h0AA, 10'h005, 10'h13C};
    exp_err = 1;
    run_txn("frm_abort");

    clear_exp();
    cmd_q = '{10'h055};
    exp_err = 1;
    run_txn("unknown");

    clear_exp();
    cmd_q = '{10'h0BB, 10'h001};
    rd_delay = 0; exp_rd.push_back(4'h1); exp_err = 1;
    run_txn("rd_timeout");
    check("rd_timeout.cycles", err_cyc - rden_cyc, TMO);

    clear_exp();
    cmd_q = '{10'h0DD, 10'h001};
    alu_delay = 3; alu_value = 16'hA55A; full_hold = 10;
    exp_alu.push_back(4'h1); exp_tx.push_back(8'h5A); exp_tx.push_back(8'hA5);
    run_txn("full_hold");
    check("full_hold.gap", 32'((first_push_cyc - vld_cyc) >= 10), 32'd1);

    clear_exp();
    cmd_q = '{10'h0DD, 10'h007};
    alu_delay = 0; exp_alu.push_back(4'h7); exp_err = 1;
    run_txn("alu_timeout");
    check("alu_timeout.cycles", err_cyc - alu_en_cyc, TMO);

    // Reset after the function byte, one cycle before the ALU start strobe would fire.
    @(negedge CLK);
    send(10'h0DD);
    send(10'h003);
    #1;
    check("rst_mid.gate_before", CLK_GATE_EN, 1'b1);
    #1;
    RST = 1'b1;
    #1;
    check("rst_mid.outputs", {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                              CLK_GATE_EN, tx_data, tx_push, busy, cmd_err}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    got_alu.delete(); got_wr.delete(); got_rd.delete(); got_tx.delete(); err_seen = 0;
    repeat (10) @(negedge CLK);
    #2;
    check("rst_mid.no_strobe", got_alu.size() + got_wr.size() + got_rd.size() + got_tx.size() + err_seen, 0);
    check("rst_mid.idle", {busy, CLK_GATE_EN}, 2'b00);
    $display("TXN %-12s reset during ALU start", "rst_mid");

    for (int t = 0; t < 40; t++) begin
      clear_exp();
      build_random(name);
      run_txn(name);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule
